// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, almost-full/empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             push_ok;
    logic             pop_ok;

    // Flags depend only on the registered count, never on the request inputs.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        pop_ok  = rd_en & ~empty;
        push_ok = wr_en & (~full | pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en & ~push_ok) overflow  <= 1'b1;
            if (rd_en & ~pop_ok)  underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wptr[AW-1:0]] <= wr_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented straight from the array while the FIFO holds data.
            always_comb begin
                rd_valid = ~empty;
                rd_data  = empty ? '0 : mem[rptr[AW-1:0]];
            end
        end else begin : g_std
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else if (flush) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= pop_ok;
                    if (pop_ok) rd_data <= mem[rptr[AW-1:0]];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a queue-based model checked every cycle on
// a standard-read and an FWFT instance, plus hand-computed directed expectations.
module tb_sync_fifo_param;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;

    logic [7:0] rd_data0, rd_data1;
    logic       rd_valid0, rd_valid1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] count0, count1;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(4)) dut_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(4)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1)
    );

    // Model: contents as a queue, plus the standard-read output register and sticky flags.
    logic [7:0] m_q[$];
    logic [7:0] m_rdd0;
    logic       m_rdv0;
    logic       m_ovf;
    logic       m_udf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_rdd0 = '0;
            m_rdv0 = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_rdd0 = '0;
            m_rdv0 = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else begin
            bit pop, push;
            pop  = rd_en && (m_q.size() > 0);
            push = wr_en && ((m_q.size() < DEPTH) || pop);
            if (wr_en && !push) m_ovf = 1'b1;
            if (rd_en && !pop)  m_udf = 1'b1;
            m_rdv0 = pop;
            if (pop)  m_rdd0 = m_q.pop_front();
            if (push) m_q.push_back(wr_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            int n;
            n = m_q.size();
            chk("count_std",  32'(count0), 32'(n));
            chk("count_fwft", 32'(count1), 32'(n));
            chk("full",   32'(full0),  32'(n == DEPTH));
            chk("empty",  32'(empty0), 32'(n == 0));
            chk("afull",  32'(af0),    32'(n >= 12));
            chk("aempty", 32'(ae0),    32'(n <= 4));
            chk("full_f",  32'(full1),  32'(n == DEPTH));
            chk("empty_f", 32'(empty1), 32'(n == 0));
            chk("afull_f", 32'(af1),    32'(n >= 12));
            chk("aempty_f",32'(ae1),    32'(n <= 4));
            chk("ovf",   32'(ovf0), 32'(m_ovf));
            chk("udf",   32'(udf0), 32'(m_udf));
            chk("ovf_f", 32'(ovf1), 32'(m_ovf));
            chk("udf_f", 32'(udf1), 32'(m_udf));
            chk("rd_valid_std", 32'(rd_valid0), 32'(m_rdv0));
            chk("rd_data_std",  32'(rd_data0),  32'(m_rdd0));
            chk("rd_valid_fwft", 32'(rd_valid1), 32'(n > 0));
            chk("rd_data_fwft",  32'(rd_data1),  (n > 0) ? 32'(m_q[0]) : 32'd0);
        end
    end

    // Apply one cycle of requests; returns 2 time units after the edge that consumed them.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic f);
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        @(posedge clk);
        #2;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        run_cmp = 1'b1;

        chk("rst_count",  32'(count0), 32'd0);
        chk("rst_empty",  32'(empty0), 32'd1);
        chk("rst_afull",  32'(af0), 32'd0);
        chk("rst_aempty", 32'(ae0), 32'd1);
        chk("rst_rdv",    32'(rd_valid0), 32'd0);

        // Fill 0x00..0x0F; almost_full first seen after the 12th push.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 10) chk("fill_af_11", 32'(af0), 32'd0);
            if (i == 11) chk("fill_af_12", 32'(af0), 32'd1);
        end
        chk("fill_count", 32'(count0), 32'd16);
        chk("fill_full",  32'(full0), 32'd1);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data",  32'(rd_data0), 32'(i));
            chk("drain_valid", 32'(rd_valid0), 32'd1);
        end
        chk("drain_empty", 32'(empty0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("idle_rdv", 32'(rd_valid0), 32'd0);
        chk("idle_hold", 32'(rd_data0), 32'h0F);

        // Wrap: 10 through, then 16 across the pointer wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap1_last", 32'(rd_data0), 32'h49);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        chk("wrap_full", 32'(full0), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_data", 32'(rd_data0), 32'(8'h80 + i));
        end

        // Simultaneous push/pop at full, then at empty.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        chk("sim_full_count", 32'(count0), 32'd16);
        chk("sim_full_ovf",   32'(ovf0), 32'd0);
        chk("sim_full_data",  32'(rd_data0), 32'h10);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("sim_last_a5", 32'(rd_data0), 32'hA5);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("sim_empty_count", 32'(count0), 32'd1);
        chk("sim_empty_udf",   32'(udf0), 32'd1);
        chk("sim_empty_rdv",   32'(rd_valid0), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("flush_udf",   32'(udf0), 32'd0);
        chk("flush_count", 32'(count0), 32'd0);

        // Overflow: refused 0x33 never appears at the read port.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("ovf_set",   32'(ovf0), 32'd1);
        chk("ovf_count", 32'(count0), 32'd16);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_last", 32'(rd_data0), 32'h2F);
        chk("ovf_sticky", 32'(ovf0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_flush", 32'(ovf0), 32'd0);

        // Flush wins over concurrent push/pop on a non-empty FIFO.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1);
        chk("flush_prio_count", 32'(count0), 32'd0);
        chk("flush_prio_rdv",   32'(rd_valid0), 32'd0);
        chk("flush_prio_rdd",   32'(rd_data0), 32'd0);
        chk("flush_prio_fwft",  32'(rd_valid1), 32'd0);

        // FWFT: word pushed into empty FIFO visible next cycle without rd_en.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_valid", 32'(rd_valid1), 32'd1);
        chk("fwft_data",  32'(rd_data1), 32'h5A);
        chk("fwft_std_rdv", 32'(rd_valid0), 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_popped", 32'(rd_valid1), 32'd0);

        // Asynchronous reset between edges with seven words stored.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count0), 32'd7);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count0), 32'd0);
        chk("arst_empty", 32'(empty0), 32'd1);
        chk("arst_fwft_rdv", 32'(rd_valid1), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_udf", 32'(udf0), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
